// File: rtl/sprite_reader_pkg.sv
// sprite_pkg: definitions shared by the sprite read path.
// Holds the pixel tag carried alongside every ROM read, the default
// transparent colour key and the reader FSM state encoding.
// No ports; imported with "import sprite_pkg::*".
package sprite_pkg;

    // Magenta is the colour the art tools export for "transparent".
    localparam logic [15:0] KEY_DEFAULT = 16'hF81F;

    // Sprite coordinates are 7 bits wide, which covers sprites up to 128x128.
    localparam int COORD_W = 7;

    // Display coordinate and end-of-sprite marker for one pixel.
    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic               last;
    } pix_tag_t;

    // Reader FSM state encoding.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/sprite_reader_if.sv
// sprite_reader_if: bundles the ROM read port and the pixel stream of the
// sprite reader.
//   rom_addr   : read address to the sprite ROM
//   rom_data   : ROM word, valid one cycle after the address is sampled
//   pix_valid  : a pixel is presented         pix_ready : consumer accepts it
//   pix_data   : RGB565 colour                pix_x/pix_y : display coordinate
//   pix_opaque : colour differs from the key  pix_last  : final pixel of the sprite
// Modport master is the reader; modport slave is the ROM plus compositor side.
interface sprite_reader_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic              pix_valid;
    logic              pix_ready;
    logic [DATA_W-1:0] pix_data;
    logic [6:0]        pix_x;
    logic [6:0]        pix_y;
    logic              pix_opaque;
    logic              pix_last;

    modport master (
        output rom_addr,
        input  rom_data,
        output pix_valid,
        input  pix_ready,
        output pix_data,
        output pix_x,
        output pix_y,
        output pix_opaque,
        output pix_last
    );

    modport slave (
        input  rom_addr,
        output rom_data,
        input  pix_valid,
        output pix_ready,
        input  pix_data,
        input  pix_x,
        input  pix_y,
        input  pix_opaque,
        input  pix_last
    );
endinterface

// File: rtl/sprite_reader_fifo.sv
// pix_fifo2: a 2-entry synchronous FIFO that other sprite paths can reuse.
//   clka, rsta : clock and asynchronous active-high reset
//   push, din  : write request and data (ignored when full with no pop)
//   pop        : read request; the head advances (ignored when empty)
//   dout       : current head entry
//   count      : number of entries held (0..2)
// A push and a pop in the same cycle are both honoured, even when full.
module pix_fifo2 #(
    parameter int W = 31
) (
    input  logic         clka,
    input  logic         rsta,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic [1:0]   count
);
    logic [W-1:0] mem [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic         do_push;
    logic         do_pop;

    // When full, a push is accepted only if the head leaves in the same
    // cycle, so the slot being written is always free.
    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);
    assign dout    = mem[rd_ptr];

    // Storage, pointers and occupancy. Entries reset to zero so the head
    // reads as an all-zero word out of reset.
    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/sprite_reader.sv
// sprite_reader: walks a sprite ROM row by row, optionally mirrored
// horizontally, and streams pixels with their display coordinates.
//   clka, rsta : clock and asynchronous active-high reset
//   start      : one-cycle request, honoured only while idle
//   flip       : horizontal mirror, captured when start is accepted
//   busy       : a sprite is in progress
//   done       : one-cycle pulse after the last pixel is accepted
//   bus        : ROM read port and valid/ready pixel stream (master side)
// The ROM answers one cycle after it samples the address. Each read carries
// its coordinate tag through a 1-deep pipeline so it can be written into a
// 2-entry output FIFO together with the returning word.
module sprite_reader
    import sprite_pkg::*;
#(
    parameter int              IMG_W  = 90,
    parameter int              IMG_H  = 90,
    parameter int              ADDR_W = 13,
    parameter int              DATA_W = 16,
    parameter logic [DATA_W-1:0] KEY  = KEY_DEFAULT
) (
    input  logic clka,
    input  logic rsta,
    input  logic start,
    input  logic flip,
    output logic busy,
    output logic done,
    sprite_reader_if.master bus
);
    localparam logic [1:0] IDLE  = ST_IDLE;
    localparam logic [1:0] RUN   = ST_RUN;
    localparam logic [1:0] DRAIN = ST_DRAIN;
    localparam int FIFO_W = DATA_W + $bits(pix_tag_t);

    logic [1:0]        state;
    logic              flip_q;
    logic [6:0]        col;
    logic [6:0]        row;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] row_base;
    logic              tag_valid;
    pix_tag_t          tag_q;
    pix_tag_t          head_tag;
    logic [DATA_W-1:0] head_data;
    logic [1:0]        fifo_count;
    logic [FIFO_W-1:0] fifo_dout;
    logic              pop;
    logic              issue;
    logic              last_col;
    logic              last_row;
    logic [2:0]        occ;

    // A read is issued only if its word is guaranteed a FIFO slot. That is
    // the case when the words already held plus the word in flight, minus
    // any word leaving this cycle, number fewer than two.
    assign last_col = (col == 7'(IMG_W - 1));
    assign last_row = (row == 7'(IMG_H - 1));
    assign pop      = bus.pix_valid & bus.pix_ready;
    assign occ      = {1'b0, fifo_count} + {2'b0, tag_valid};
    assign issue    = (state == RUN) && (occ < (3'd2 + {2'b0, pop}));
    assign busy     = (state != IDLE);

    // Sequencer: captures the request, then steps the column and row counters
    // and the ROM address once per issued read. Row starts come from a
    // running base stepped by IMG_W so no multiplier is needed. A mirrored
    // row starts at its right-hand end and counts down. After the final
    // read the FSM waits in DRAIN until the last pixel has been accepted.
    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            state    <= IDLE;
            flip_q   <= 1'b0;
            col      <= 7'd0;
            row      <= 7'd0;
            addr     <= '0;
            row_base <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= RUN;
                        flip_q   <= flip;
                        col      <= 7'd0;
                        row      <= 7'd0;
                        row_base <= '0;
                        addr     <= flip ? ADDR_W'(IMG_W - 1) : '0;
                    end
                end
                RUN: begin
                    if (issue) begin
                        if (last_col) begin
                            if (last_row) begin
                                state <= DRAIN;
                            end else begin
                                col      <= 7'd0;
                                row      <= row + 7'd1;
                                row_base <= row_base + ADDR_W'(IMG_W);
                                addr     <= flip_q ? row_base + ADDR_W'(2 * IMG_W - 1)
                                                   : row_base + ADDR_W'(IMG_W);
                            end
                        end else begin
                            col  <= col + 7'd1;
                            addr <= flip_q ? addr - ADDR_W'(1) : addr + ADDR_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (pop && head_tag.last) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag pipeline: records the display coordinate of the read issued this
    // cycle so it meets its ROM word on the following cycle.
    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            tag_valid <= 1'b0;
            tag_q     <= '0;
        end else begin
            tag_valid <= issue;
            if (issue) begin
                tag_q.x    <= col;
                tag_q.y    <= row;
                tag_q.last <= last_col && last_row;
            end
        end
    end

    pix_fifo2 #(
        .W(FIFO_W)
    ) u_fifo (
        .clka (clka),
        .rsta (rsta),
        .push (tag_valid),
        .din  ({bus.rom_data, tag_q}),
        .pop  (pop),
        .dout (fifo_dout),
        .count(fifo_count)
    );

    assign {head_data, head_tag} = fifo_dout;
    assign bus.rom_addr   = addr;
    assign bus.pix_valid  = (fifo_count != 2'd0);
    assign bus.pix_data   = head_data;
    assign bus.pix_x      = head_tag.x;
    assign bus.pix_y      = head_tag.y;
    assign bus.pix_last   = head_tag.last;
    assign bus.pix_opaque = (head_data != KEY);

endmodule

// File: tb/tb_sprite_reader.sv
// tb_sprite_reader: scoreboard bench for sprite_reader on a 90x90 ROM model.
// Every word equals its address except word 5, which holds the colour key.
// Each sprite request queues its expected pixel stream, and a monitor
// compares every accepted pixel against the head of that queue.
module tb_sprite_reader;
    import sprite_pkg::*;

    localparam int W    = 90;
    localparam int H    = 90;
    localparam int NPIX = W * H;

    typedef struct packed {
        logic [15:0] data;
        logic [6:0]  x;
        logic [6:0]  y;
        logic        last;
        logic        opaque;
    } exp_t;

    logic clka = 1'b0;
    logic rsta;
    logic start;
    logic flip;
    logic busy;
    logic done;

    exp_t expQ[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   popped      = 0;
    bit   randReady   = 1'b0;

    sprite_reader_if #(.ADDR_W(13), .DATA_W(16)) bus ();

    sprite_reader #(
        .IMG_W (W),
        .IMG_H (H),
        .ADDR_W(13),
        .DATA_W(16),
        .KEY   (16'hF81F)
    ) dut (
        .clka (clka),
        .rsta (rsta),
        .start(start),
        .flip (flip),
        .busy (busy),
        .done (done),
        .bus  (bus)
    );

    always #5 clka = ~clka;

    function automatic logic [15:0] romWord(input logic [12:0] a);
        return (a == 13'd5) ? 16'hF81F : {3'b000, a};
    endfunction

    // Registered ROM model with one cycle of read latency.
    always_ff @(posedge clka) begin
        bus.rom_data <= romWord(bus.rom_addr);
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic pushExpected(input bit f);
        exp_t e;
        for (int k = 0; k < NPIX; k++) begin
            int x;
            int y;
            int a;
            y      = k / W;
            x      = k % W;
            a      = f ? (y * W + (W - 1 - x)) : (y * W + x);
            e.data = romWord(13'(a));
            e.x    = 7'(x);
            e.y    = 7'(y);
            e.last = (k == NPIX - 1);
            e.opaque = (e.data != 16'hF81F);
            expQ.push_back(e);
        end
    endtask

    // Consumer: always ready, or ready about 30% of cycles; changes mid-cycle.
    initial begin
        bus.pix_ready = 1'b1;
        forever begin
            @(posedge clka);
            #2;
            bus.pix_ready = randReady ? ($urandom_range(0, 99) < 30) : 1'b1;
        end
    end

    // Monitor: scoreboards each handshake, and under random backpressure
    // checks that the address holds once two consecutive stalls have filled
    // the FIFO plus the in-flight slot.
    always @(negedge clka) begin : monitor
        exp_t        e;
        exp_t        got;
        bit          stallPrev;
        bit          stallNow;
        bit          holdArmed;
        logic [12:0] heldAddr;
        if (!rsta && bus.pix_valid && bus.pix_ready) begin
            got = {bus.pix_data, bus.pix_x, bus.pix_y, bus.pix_last, bus.pix_opaque};
            if (expQ.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL extra_pixel: got %0h expected none", got);
            end else begin
                e = expQ.pop_front();
                checkOutput("pixel", 32'(got), 32'(e));
                popped++;
            end
        end
        stallNow = !rsta && busy && bus.pix_valid && !bus.pix_ready;
        if (randReady && holdArmed) begin
            checkOutput("addr_hold", 32'(bus.rom_addr), 32'(heldAddr));
        end
        holdArmed = randReady && stallPrev && stallNow;
        heldAddr  = bus.rom_addr;
        stallPrev = stallNow;
    end

    task automatic applyStimulus(input bit f, input bit poke, input bit checkTiming);
        int cycles;
        @(negedge clka);
        start = 1'b1;
        flip  = f;
        pushExpected(f);
        @(posedge clka);
        #1;
        start = 1'b0;
        flip  = ~f;
        checkOutput("busy_after_start", 32'(busy), 32'd1);
        checkOutput("first_addr", 32'(bus.rom_addr), f ? 32'd89 : 32'd0);
        checkOutput("valid_c0", 32'(bus.pix_valid), 32'd0);
        cycles = 0;
        while (!done && cycles < 60000) begin
            @(posedge clka);
            cycles++;
            #1;
            if (cycles == 1) checkOutput("valid_c1", 32'(bus.pix_valid), 32'd0);
            if (cycles == 2) checkOutput("valid_c2", 32'(bus.pix_valid), 32'd1);
            if (poke && cycles == 3000) start = 1'b1;
            if (poke && cycles == 3001) start = 1'b0;
        end
        checkOutput("done_seen", 32'(done), 32'd1);
        if (checkTiming) checkOutput("start_to_done", 32'(cycles), 32'(NPIX + 2));
        checkOutput("busy_at_done", 32'(busy), 32'd0);
        checkOutput("queue_empty_at_done", 32'(expQ.size()), 32'd0);
    endtask

    task automatic abortSprite(input int pixels);
        int n;
        int target;
        target = popped + pixels;
        @(negedge clka);
        start = 1'b1;
        flip  = 1'b0;
        pushExpected(1'b0);
        @(posedge clka);
        #1;
        start = 1'b0;
        n = 0;
        while (popped < target && n < 20000) begin
            @(posedge clka);
            n++;
        end
        checkOutput("abort_reached", 32'(popped >= target), 32'd1);
        #3;
        rsta = 1'b1;
        #1;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_valid", 32'(bus.pix_valid), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        expQ.delete();
        @(negedge clka);
        @(negedge clka);
        rsta = 1'b0;
        repeat (3) @(negedge clka);
        checkOutput("abort_idle_valid", 32'(bus.pix_valid), 32'd0);
        checkOutput("abort_idle_done", 32'(done), 32'd0);
    endtask

    initial begin
        rsta  = 1'b1;
        start = 1'b0;
        flip  = 1'b0;
        repeat (3) @(negedge clka);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_valid", 32'(bus.pix_valid), 32'd0);
        checkOutput("rst_addr", 32'(bus.rom_addr), 32'd0);
        checkOutput("rst_x", 32'(bus.pix_x), 32'd0);
        checkOutput("rst_y", 32'(bus.pix_y), 32'd0);
        checkOutput("rst_last", 32'(bus.pix_last), 32'd0);
        checkOutput("rst_data", 32'(bus.pix_data), 32'd0);
        checkOutput("rst_opaque", 32'(bus.pix_opaque), 32'd1);
        rsta = 1'b0;

        $display("[TB] plain sprite with ignored mid-sprite start");
        applyStimulus(1'b0, 1'b1, 1'b1);
        $display("[TB] back-to-back mirrored sprite");
        applyStimulus(1'b1, 1'b0, 1'b1);
        $display("[TB] random backpressure");
        randReady = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        randReady = 1'b0;
        $display("[TB] reset mid-sprite, then restart");
        abortSprite(1000);
        applyStimulus(1'b0, 1'b0, 1'b1);

        repeat (5) @(negedge clka);
        checkOutput("final_queue_empty", 32'(expQ.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #950000;
        miscompares++;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
